// File: rtl/dial_quad.sv
// Quadrature dial emulator: converts queued spinner deltas and held buttons
// into a rate-limited two-bit Gray-code phase sequence for a game's dial input.
`timescale 1ns/1ps

module dial_quad #(
  parameter int unsigned STEP_DIV = 12000,
  parameter int unsigned ACC_W    = 10
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       en,
  input  logic       invert,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] spin_delta,
  input  logic       spin_strobe,
  output logic [1:0] dial,
  output logic       busy
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned SUM_W = ACC_W + 2;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic signed [SUM_W-1:0] SAT_POS  = SUM_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_NEG  = -SAT_POS;

  // Encoding each phase as its own dial value lets the output be the state register.
  typedef enum logic [1:0] {
    PH_0 = 2'b00,
    PH_1 = 2'b01,
    PH_2 = 2'b10,
    PH_3 = 2'b11
  } phase_t;

  logic [CNT_W-1:0]        div_cnt;
  logic                    tick;
  logic                    strobe_q;
  logic                    strobe_ev;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [SUM_W-1:0] acc_ext;
  logic signed [SUM_W-1:0] delta_ext;
  logic signed [SUM_W-1:0] acc_step;
  logic signed [SUM_W-1:0] acc_sum;
  logic                    step_en;
  logic                    step_fwd;
  logic                    dir_fwd;
  phase_t                  phase;
  phase_t                  phase_next;

  // Free-running step-rate divider.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering-dependent logic.
  always_ff @(posedge clk_sys) begin
    if (reset || tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + CNT_W'(1);
  end

  assign tick      = (div_cnt == CNT_LAST);
  assign strobe_ev = (spin_strobe != strobe_q);

  // Step source selection: pending accumulator first, buttons only when it is empty.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    step_en  = 1'b0;
    step_fwd = 1'b0;
    acc_step = '0;
    if (tick && en) begin
      if (acc != '0) begin
        step_en  = 1'b1;
        step_fwd = ~acc[ACC_W-1];
        acc_step = acc[ACC_W-1] ? '1 : SUM_W'(1);
      end else if (btn_down ^ btn_up) begin
        step_en  = 1'b1;
        step_fwd = btn_down;
      end
    end
  end

  assign dir_fwd = step_fwd ^ invert;

  // Delta add and step retire share one sum so the result saturates only once.
  always_comb begin
    acc_ext   = {{2{acc[ACC_W-1]}}, acc};
    delta_ext = (strobe_ev && en) ? {{(SUM_W-8){spin_delta[7]}}, spin_delta} : '0;
    acc_sum   = acc_ext + delta_ext - acc_step;
    if (acc_sum > SAT_POS)      acc_next = SAT_POS[ACC_W-1:0];
    else if (acc_sum < SAT_NEG) acc_next = SAT_NEG[ACC_W-1:0];
    else                        acc_next = acc_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk_sys) begin
    strobe_q <= spin_strobe;
    if (reset || !en) begin
      acc  <= '0;
      busy <= 1'b0;
    end else begin
      acc  <= acc_next;
      busy <= (acc_next != '0);
    end
  end

  // Phase FSM: state register.
  always_ff @(posedge clk_sys) begin
    if (reset) phase <= PH_3;
    else       phase <= phase_next;
  end

  // Phase FSM: next state. Forward is 3-1-0-2, reverse is 3-2-0-1.
  always_comb begin
    phase_next = phase;
    if (!en) begin
      phase_next = PH_3;
    end else if (step_en) begin
      unique case (phase)
        PH_3: phase_next = dir_fwd ? PH_1 : PH_2;
        PH_1: phase_next = dir_fwd ? PH_0 : PH_3;
        PH_0: phase_next = dir_fwd ? PH_2 : PH_1;
        PH_2: phase_next = dir_fwd ? PH_3 : PH_0;
        default: phase_next = PH_3;
      endcase
    end
  end

  // Phase FSM: output decode.
  always_comb begin
    dial = phase;
  end

endmodule
